// File: rtl/sine_meas_pkg.sv
// Shared types and default parameters for the sine period meter.
//   xing_state_t : comparator state (S_INIT, S_LOW, S_HIGH)
//   DEF_*        : default sample width, counter width, thresholds, timeout
package sine_meas_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } xing_state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_MIDPOINT   = 128;
  localparam int DEF_HYST       = 8;
  localparam int DEF_MAX_PERIOD = 4095;

endpackage

// File: rtl/sine_xing_detect.sv
// Hysteresis comparator for the sample stream.
//   clk_in, rst_n : clock, async active-low reset
//   sample_valid  : qualifies sample; the FSM only moves on valid samples
//   sample        : unsigned sample
//   state         : comparator state after the current sample is applied
//   rise          : S_LOW -> S_HIGH transition on this (valid) sample
module sine_xing_detect
  import sine_meas_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MIDPOINT = DEF_MIDPOINT,
  parameter int HYST     = DEF_HYST
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output xing_state_t       state,
  output logic              rise
);

  // Thresholds carry one extra bit so MIDPOINT+HYST cannot wrap.
  localparam logic [DATA_W:0] HI_TH_C = (DATA_W+1)'(MIDPOINT + HYST);
  localparam logic [DATA_W:0] LO_TH_C = (DATA_W+1)'(MIDPOINT - HYST);

  xing_state_t     state_r;
  xing_state_t     state_nxt_s;
  logic            rise_s;
  logic [DATA_W:0] sample_ext_s;
  logic            ge_hi_s;
  logic            le_lo_s;

  assign sample_ext_s = {1'b0, sample};
  assign ge_hi_s      = (sample_ext_s >= HI_TH_C);
  assign le_lo_s      = (sample_ext_s <= LO_TH_C);

  // Comparator state register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and rise-event decode; samples inside the band never move the FSM.
  always_comb begin
    state_nxt_s = state_r;
    rise_s      = 1'b0;
    if (sample_valid) begin
      case (state_r)
        S_INIT: begin
          if (le_lo_s) begin
            state_nxt_s = S_LOW;
          end else if (ge_hi_s) begin
            state_nxt_s = S_HIGH;
          end else begin
            state_nxt_s = S_INIT;
          end
        end
        S_LOW: begin
          if (ge_hi_s) begin
            state_nxt_s = S_HIGH;
            rise_s      = 1'b1;
          end else begin
            state_nxt_s = S_LOW;
          end
        end
        S_HIGH: begin
          if (le_lo_s) begin
            state_nxt_s = S_LOW;
          end else begin
            state_nxt_s = S_HIGH;
          end
        end
        default: begin
          state_nxt_s = S_INIT;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign state = state_nxt_s;
  assign rise  = rise_s;

endmodule

// File: rtl/sine_period_meter.sv
// Per-cycle waveform measurement of an 8-bit unsigned sample stream.
//   clk_in, rst_n      : clock, async active-low reset
//   sample_valid       : qualifies sample (no backpressure)
//   sample             : unsigned sample
//   meas_valid         : one-cycle pulse with a new measurement
//   period             : accepted samples in the last complete cycle
//   peak_max, peak_min : extremes of the last complete cycle
//   high_samples       : samples of the last cycle with the comparator HIGH
//   locked             : a measurement exists and no timeout since
//   timeout            : sticky; cleared by the next measurement
module sine_period_meter
  import sine_meas_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MIDPOINT   = DEF_MIDPOINT,
  parameter int HYST       = DEF_HYST,
  parameter int MAX_PERIOD = DEF_MAX_PERIOD
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  period,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  output logic [CNT_W-1:0]  high_samples,
  output logic              locked,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_PERIOD);

  function automatic logic [DATA_W-1:0] max_f(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    if (a > b) return a;
    else       return b;
  endfunction

  function automatic logic [DATA_W-1:0] min_f(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    if (a < b) return a;
    else       return b;
  endfunction

  xing_state_t       xing_state_s;
  logic              rise_s;

  logic [CNT_W-1:0]  cnt_r,        cnt_nxt_s;
  logic [DATA_W-1:0] run_max_r,    run_max_nxt_s;
  logic [DATA_W-1:0] run_min_r,    run_min_nxt_s;
  logic [CNT_W-1:0]  run_high_r,   run_high_nxt_s;
  logic              armed_r,      armed_nxt_s;
  logic              meas_valid_r, meas_valid_nxt_s;
  logic [CNT_W-1:0]  period_r,     period_nxt_s;
  logic [DATA_W-1:0] peak_max_r,   peak_max_nxt_s;
  logic [DATA_W-1:0] peak_min_r,   peak_min_nxt_s;
  logic [CNT_W-1:0]  high_r,       high_nxt_s;
  logic              locked_r,     locked_nxt_s;
  logic              timeout_r,    timeout_nxt_s;

  sine_xing_detect #(
    .DATA_W   (DATA_W),
    .MIDPOINT (MIDPOINT),
    .HYST     (HYST)
  ) u_xing (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .state        (xing_state_s),
    .rise         (rise_s)
  );

  // Window accumulation, measurement latch and lock/timeout decisions.
  always_comb begin
    cnt_nxt_s        = cnt_r;
    run_max_nxt_s    = run_max_r;
    run_min_nxt_s    = run_min_r;
    run_high_nxt_s   = run_high_r;
    armed_nxt_s      = armed_r;
    meas_valid_nxt_s = 1'b0;
    period_nxt_s     = period_r;
    peak_max_nxt_s   = peak_max_r;
    peak_min_nxt_s   = peak_min_r;
    high_nxt_s       = high_r;
    locked_nxt_s     = locked_r;
    timeout_nxt_s    = timeout_r;
    if (sample_valid) begin
      if (rise_s) begin
        // A rise closes the current window (if one is open) and opens the next;
        // it takes precedence over a coincident timeout.
        if (armed_r) begin
          period_nxt_s     = cnt_r;
          peak_max_nxt_s   = run_max_r;
          peak_min_nxt_s   = run_min_r;
          high_nxt_s       = run_high_r;
          meas_valid_nxt_s = 1'b1;
          locked_nxt_s     = 1'b1;
          timeout_nxt_s    = 1'b0;
        end else begin
          meas_valid_nxt_s = 1'b0;
        end
        cnt_nxt_s      = ONE_C;
        run_max_nxt_s  = sample;
        run_min_nxt_s  = sample;
        run_high_nxt_s = ONE_C;
        armed_nxt_s    = 1'b1;
      end else if (armed_r) begin
        if (cnt_r == MAX_C) begin
          // Window too long: drop lock and wait for a fresh arming rise.
          timeout_nxt_s = 1'b1;
          locked_nxt_s  = 1'b0;
          armed_nxt_s   = 1'b0;
        end else begin
          cnt_nxt_s      = cnt_r + ONE_C;
          run_max_nxt_s  = max_f(run_max_r, sample);
          run_min_nxt_s  = min_f(run_min_r, sample);
          run_high_nxt_s = run_high_r + ((xing_state_s == S_HIGH) ? ONE_C : ZERO_C);
        end
      end else begin
        armed_nxt_s = 1'b0;
      end
    end else begin
      meas_valid_nxt_s = 1'b0;
    end
  end

  // Window and output registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= ZERO_C;
      run_max_r    <= {DATA_W{1'b0}};
      run_min_r    <= {DATA_W{1'b1}};
      run_high_r   <= ZERO_C;
      armed_r      <= 1'b0;
      meas_valid_r <= 1'b0;
      period_r     <= ZERO_C;
      peak_max_r   <= {DATA_W{1'b0}};
      peak_min_r   <= {DATA_W{1'b0}};
      high_r       <= ZERO_C;
      locked_r     <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      run_max_r    <= run_max_nxt_s;
      run_min_r    <= run_min_nxt_s;
      run_high_r   <= run_high_nxt_s;
      armed_r      <= armed_nxt_s;
      meas_valid_r <= meas_valid_nxt_s;
      period_r     <= period_nxt_s;
      peak_max_r   <= peak_max_nxt_s;
      peak_min_r   <= peak_min_nxt_s;
      high_r       <= high_nxt_s;
      locked_r     <= locked_nxt_s;
      timeout_r    <= timeout_nxt_s;
    end
  end

  assign meas_valid   = meas_valid_r;
  assign period       = period_r;
  assign peak_max     = peak_max_r;
  assign peak_min     = peak_min_r;
  assign high_samples = high_r;
  assign locked       = locked_r;
  assign timeout      = timeout_r;

endmodule

// File: tb/tb_sine_period_meter.sv
// Directed, scoreboard-checked bench for sine_period_meter (MAX_PERIOD = 100).
module tb_sine_period_meter;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int MAXP   = 100;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic              sample_valid;
  logic [DATA_W-1:0] sample;
  logic              meas_valid;
  logic [CNT_W-1:0]  period;
  logic [DATA_W-1:0] peak_max;
  logic [DATA_W-1:0] peak_min;
  logic [CNT_W-1:0]  high_samples;
  logic              locked;
  logic              timeout;

  sine_period_meter #(
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W),
    .MIDPOINT   (128),
    .HYST       (8),
    .MAX_PERIOD (MAXP)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .meas_valid   (meas_valid),
    .period       (period),
    .peak_max     (peak_max),
    .peak_min     (peak_min),
    .high_samples (high_samples),
    .locked       (locked),
    .timeout      (timeout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int period;
    int pmax;
    int pmin;
    int high;
  } meas_t;

  meas_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    lut[64];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, then check pulse and scoreboard.
  task automatic step(input bit v, input int s, input bit exp_meas);
    meas_t e;
    sample_valid = v;
    sample       = s[DATA_W-1:0];
    @(posedge clk_in);
    #1;
    sample_valid = 1'b0;
    chk("meas_valid", int'(meas_valid), int'(exp_meas));
    if (meas_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("period",       int'(period),       e.period);
        chk("peak_max",     int'(peak_max),     e.pmax);
        chk("peak_min",     int'(peak_min),     e.pmin);
        chk("high_samples", int'(high_samples), e.high);
        chk("locked@meas",  int'(locked),       1);
        chk("timeout@meas", int'(timeout),      0);
      end
    end
  endtask

  // Valid sample followed by gap-1 idle cycles.
  task automatic send(input int s, input bit exp_meas, input meas_t e, input int gap);
    if (exp_meas) sb_q.push_back(e);
    step(1'b1, s, exp_meas);
    for (int g = 1; g < gap; g++) step(1'b0, 0, 1'b0);
  endtask

  // ncyc cycles of 10x200 then 10x50; rises in cycles >= first_meas expect a measurement.
  task automatic pattern(input int ncyc, input int gap, input int first_meas);
    meas_t e;
    e = '{20, 200, 50, 10};
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 10; i++) send(200, (i == 0) && (c >= first_meas), e, gap);
      for (int i = 0; i < 10; i++) send(50, 1'b0, e, gap);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".meas_valid"},   int'(meas_valid),   0);
    chk({tag, ".period"},       int'(period),       0);
    chk({tag, ".peak_max"},     int'(peak_max),     0);
    chk({tag, ".peak_min"},     int'(peak_min),     0);
    chk({tag, ".high_samples"}, int'(high_samples), 0);
    chk({tag, ".locked"},       int'(locked),       0);
    chk({tag, ".timeout"},      int'(timeout),      0);
  endtask

  initial begin
    real   v;
    meas_t e;
    meas_t e_sine;
    meas_t e_first;
    int    r;
    int    fall;
    int    smax;
    int    smin;

    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;

    for (int i = 0; i < 64; i++) begin
      v = 127.5 + 127.5 * $sin(2.0 * 3.141592653589793 * i / 64.0);
      lut[i] = int'($floor(v + 0.5));
      if (lut[i] > 255) lut[i] = 255;
      if (lut[i] < 0)   lut[i] = 0;
    end
    smax = 0;
    smin = 255;
    for (int i = 0; i < 64; i++) begin
      if (lut[i] > smax) smax = lut[i];
      if (lut[i] < smin) smin = lut[i];
    end
    r = -1;
    for (int i = 0; i < 64; i++) if (r < 0 && lut[i] >= 136) r = i;
    fall = -1;
    for (int i = 0; i < 64; i++) if (fall < 0 && i > r && lut[i] <= 120) fall = i;

    // Reset state.
    #12;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Continuous pattern: arm on the 2nd rise, measure from the 3rd cycle on.
    pattern(5, 1, 2);
    // Same pattern with a valid sample every 3rd cycle.
    pattern(4, 3, 0);

    // Hysteresis: in-band samples from S_LOW do nothing, 135 nothing, 136 rises.
    e = '{0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      send(130, 1'b0, e, 1);
      send(126, 1'b0, e, 1);
    end
    send(135, 1'b0, e, 1);
    e = '{41, 200, 50, 10};
    send(136, 1'b1, e, 1);

    // Timeout: 136 is window sample 1, 99 more reach cnt == MAX_PERIOD.
    for (int i = 0; i < 99; i++) send(200, 1'b0, e, 1);
    chk("locked_pre_to",  int'(locked),  1);
    chk("timeout_pre_to", int'(timeout), 0);
    send(200, 1'b0, e, 1);
    chk("timeout_set",   int'(timeout),      1);
    chk("locked_clr",    int'(locked),       0);
    chk("period_hold",   int'(period),       41);
    chk("high_hold",     int'(high_samples), 10);
    step(1'b0, 0, 1'b0);
    chk("timeout_idle",  int'(timeout),      1);
    // Recovery: first rise only re-arms, the next one measures and clears timeout.
    pattern(2, 1, 99);
    chk("timeout_armed", int'(timeout), 1);
    pattern(1, 1, 0);

    // LUT sine: first rise closes the pattern window, then period 64 per cycle.
    e_first = '{20 + r, 200, 50, 10};
    e_sine  = '{64, smax, smin, fall - r};
    for (int k = 0; k < 4 * 64; k++) begin
      send(lut[k % 64], (k % 64) == r, (k == r) ? e_first : e_sine, 1);
    end

    // Reset mid-window: the rise below measures the partial sine cycle first.
    e = '{64 - r, smax, smin, fall - r};
    send(200, 1'b1, e, 1);
    for (int i = 0; i < 4; i++) send(200, 1'b0, e, 1);
    chk("pre_rst_period", int'(period), 64 - r);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    pattern(3, 1, 2);

    chk("sb_leftover", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
